// File: rtl/note_sequencer_if.sv
// Control/status bundle between the mode/button logic and the note sequencer.
// The master drives the melody controls; the slave (sequencer) returns generator drive and status.
interface note_sequencer_if #(
    parameter int ADDR_W = 4
) ();
    logic              mode;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W:0]   seq_len;
    logic              loop;
    logic              start;
    logic              stop;
    logic [19:0]       note_period;
    logic              play;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_index;

    modport master (
        output mode, wr_en, wr_addr, wr_data, seq_len, loop, start, stop,
        input  note_period, play, busy, done, cur_index
    );

    modport slave (
        input  mode, wr_en, wr_addr, wr_data, seq_len, loop, start, stop,
        output note_period, play, busy, done, cur_index
    );
endinterface

// File: rtl/note_sequencer.sv
// Plays a stored melody by stepping through note/duration entries and driving the
// square-wave generator, with a silent gap after each note and optional looping.
module note_sequencer #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    note_sequencer_if.slave   io_seq
);

    typedef enum logic [1:0] {IDLE, LOAD, NOTE, GAP} state_t;

    // Half-period minus one for C4..B4, rounded from micro-hertz frequencies (A4 = 440 Hz).
    function automatic logic [19:0] toneConst(input int code);
        longint fUhz;
        longint half;
        case (code)
            1:       fUhz = 64'd261625565;
            2:       fUhz = 64'd277182631;
            3:       fUhz = 64'd293664768;
            4:       fUhz = 64'd311126984;
            5:       fUhz = 64'd329627557;
            6:       fUhz = 64'd349228231;
            7:       fUhz = 64'd369994423;
            8:       fUhz = 64'd391995436;
            9:       fUhz = 64'd415304698;
            10:      fUhz = 64'd440000000;
            11:      fUhz = 64'd466163762;
            12:      fUhz = 64'd493883301;
            default: fUhz = 64'd0;
        endcase
        if (fUhz == 64'd0) begin
            return 20'd0;
        end
        half = (longint'(CLK_FREQ) * 64'd1000000 + fUhz) / (64'd2 * fUhz);
        return 20'(half - 64'd1);
    endfunction

    localparam logic [19:0] TONE_TABLE [16] = '{
        toneConst(0),  toneConst(1),  toneConst(2),  toneConst(3),
        toneConst(4),  toneConst(5),  toneConst(6),  toneConst(7),
        toneConst(8),  toneConst(9),  toneConst(10), toneConst(11),
        toneConst(12), toneConst(13), toneConst(14), toneConst(15)
    };

    localparam logic [23:0] BEAT_LOAD = 24'(BEAT_CYCLES - 1);
    localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYCLES - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [23:0]       r_beatCnt;
    logic [23:0]       w_beatCnt;
    logic [3:0]        r_units;
    logic [3:0]        w_units;
    logic [ADDR_W-1:0] r_curIndex;
    logic [ADDR_W-1:0] w_curIndex;
    logic [19:0]       r_notePeriod;
    logic [19:0]       w_notePeriod;
    logic              r_play;
    logic              w_play;
    logic              r_done;
    logic              w_done;
    logic [7:0]        r_mem [DEPTH];

    logic [7:0]        w_entry;
    logic [3:0]        w_code;
    logic              w_pitched;
    logic              w_abort;
    logic              w_isLast;
    logic              w_beatDone;

    assign w_entry    = r_mem[r_curIndex];
    assign w_code     = w_entry[7:4];
    assign w_pitched  = (w_code >= 4'd1) && (w_code <= 4'd12);
    assign w_abort    = io_seq.stop || !io_seq.mode;
    assign w_isLast   = ({1'b0, r_curIndex} + (ADDR_W+1)'(1)) >= io_seq.seq_len;
    assign w_beatDone = (r_beatCnt == 24'd0);

    // Melody memory has no reset so a stored tune survives a reset pulse.
    always_ff @(posedge i_clk) begin
        if (io_seq.wr_en && (r_state == IDLE)) begin
            r_mem[io_seq.wr_addr] <= io_seq.wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_beatCnt    <= 24'd0;
            r_units      <= 4'd0;
            r_curIndex   <= '0;
            r_notePeriod <= 20'd0;
            r_play       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_beatCnt    <= w_beatCnt;
            r_units      <= w_units;
            r_curIndex   <= w_curIndex;
            r_notePeriod <= w_notePeriod;
            r_play       <= w_play;
            r_done       <= w_done;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (io_seq.start && io_seq.mode && (io_seq.seq_len != '0) && !io_seq.stop) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_nextState = w_abort ? IDLE : NOTE;
            end
            NOTE: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_beatDone && (r_units == 4'd0)) begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_beatDone) begin
                    w_nextState = (w_isLast && !io_seq.loop) ? IDLE : LOAD;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Note length is beats x units so each counter stays within 24 bits yet counts exactly.
    always_comb begin
        w_play       = 1'b0;
        w_done       = 1'b0;
        w_notePeriod = r_notePeriod;
        w_curIndex   = r_curIndex;
        w_beatCnt    = r_beatCnt;
        w_units      = r_units;
        case (r_state)
            IDLE: begin
                if (w_nextState == LOAD) begin
                    w_curIndex = '0;
                end
            end
            LOAD: begin
                if (w_nextState == NOTE) begin
                    w_play    = w_pitched;
                    w_beatCnt = BEAT_LOAD;
                    w_units   = w_entry[3:0];
                    if (w_pitched) begin
                        w_notePeriod = TONE_TABLE[w_code];
                    end
                end
            end
            NOTE: begin
                if (w_nextState == NOTE) begin
                    w_play = r_play;
                    if (w_beatDone) begin
                        w_beatCnt = BEAT_LOAD;
                        w_units   = r_units - 4'd1;
                    end else begin
                        w_beatCnt = r_beatCnt - 24'd1;
                    end
                end else if (w_nextState == GAP) begin
                    w_beatCnt = GAP_LOAD;
                end
            end
            GAP: begin
                if (w_nextState == GAP) begin
                    w_beatCnt = r_beatCnt - 24'd1;
                end else if (w_nextState == LOAD) begin
                    w_curIndex = w_isLast ? '0 : (r_curIndex + ADDR_W'(1));
                end else if (!w_abort) begin
                    w_done = 1'b1;
                end
            end
            default: begin
                w_play = 1'b0;
            end
        endcase
    end

    assign io_seq.note_period = r_notePeriod;
    assign io_seq.play        = r_play;
    assign io_seq.busy        = (r_state != IDLE);
    assign io_seq.done        = r_done;
    assign io_seq.cur_index   = r_curIndex;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: each stimulus pushes the per-cycle outputs it
// should produce, and a monitor pops and compares one sample after every rising edge.
module tb_note_sequencer;

    localparam int BEAT = 10;
    localparam int GAPC = 2;
    localparam real CLKF = 50_000_000.0;

    logic clk;
    logic rstN;
    int   checkCount;
    int   errorCount;
    int   modelPeriod;
    logic [7:0]  memModel [16];
    logic [27:0] expQ [$];

    note_sequencer_if #(.ADDR_W(4)) seqIf ();

    note_sequencer #(
        .CLK_FREQ(50_000_000),
        .DEPTH(16),
        .ADDR_W(4),
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES(GAPC)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .io_seq(seqIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent equal-tempered pitch model; -1 marks a rest code.
    function automatic int expTone(input int code);
        real f;
        if (code < 1 || code > 12) return -1;
        f = 440.0 * (2.0 ** ((code - 10) / 12.0));
        return $rtoi(CLKF / (2.0 * f) + 0.5) - 1;
    endfunction

    function automatic logic [27:0] makeSample(input logic care, input logic busy, input logic play,
                                               input logic done, input int cur, input int period);
        return {care, busy, play, done, 4'(cur), 20'(period)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Monitor: one expected sample per rising edge while the scoreboard holds entries.
    always @(posedge clk) begin
        logic [27:0] expS;
        logic [26:0] act;
        #1;
        if (expQ.size() > 0) begin
            expS = expQ.pop_front();
            act = {seqIf.busy, seqIf.play, seqIf.done, seqIf.cur_index, seqIf.note_period};
            if (!expS[27]) act[23:20] = expS[23:20];
            checkOutput("cyc", {5'd0, act}, {5'd0, expS[26:0]});
        end
    end

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++) expQ.push_back(makeSample(1'b0, 1'b0, 1'b0, 1'b0, 0, modelPeriod));
    endtask

    // noteLimit < 0 pushes the full note plus gap; otherwise only that many note cycles.
    task automatic pushEntry(input int idx, input int noteLimit);
        int code;
        int tone;
        int n;
        code = int'(memModel[idx][7:4]);
        tone = expTone(code);
        expQ.push_back(makeSample(1'b1, 1'b1, 1'b0, 1'b0, idx, modelPeriod));
        if (tone >= 0) modelPeriod = tone;
        n = (int'(memModel[idx][3:0]) + 1) * BEAT;
        if (noteLimit >= 0 && noteLimit < n) n = noteLimit;
        for (int i = 0; i < n; i++) expQ.push_back(makeSample(1'b1, 1'b1, tone >= 0, 1'b0, idx, modelPeriod));
        if (noteLimit < 0) begin
            for (int i = 0; i < GAPC; i++) expQ.push_back(makeSample(1'b1, 1'b1, 1'b0, 1'b0, idx, modelPeriod));
        end
    endtask

    task automatic pushDone(input int lastIdx);
        expQ.push_back(makeSample(1'b1, 1'b0, 1'b0, 1'b1, lastIdx, modelPeriod));
        expQ.push_back(makeSample(1'b1, 1'b0, 1'b0, 1'b0, lastIdx, modelPeriod));
    endtask

    task automatic applyStimulus(input logic startV, input logic stopV);
        @(negedge clk);
        seqIf.start = startV;
        seqIf.stop  = stopV;
    endtask

    task automatic endPulse();
        @(negedge clk);
        seqIf.start = 1'b0;
        seqIf.stop  = 1'b0;
        seqIf.wr_en = 1'b0;
        seqIf.mode  = 1'b1;
    endtask

    task automatic writeEntry(input int addr, input logic [7:0] data);
        @(negedge clk);
        seqIf.wr_en   = 1'b1;
        seqIf.wr_addr = 4'(addr);
        seqIf.wr_data = data;
        memModel[addr] = data;
        @(negedge clk);
        seqIf.wr_en = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 3000;
        while (expQ.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (expQ.size() > 0) begin
            checkOutput("drain", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
    endtask

    task automatic playMelody(input int len);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < len; i++) pushEntry(i, -1);
        pushDone(len - 1);
        endPulse();
        waitDrain();
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        modelPeriod = 0;
        rstN = 1'b0;
        seqIf.mode = 1'b1;
        seqIf.wr_en = 1'b0;
        seqIf.wr_addr = '0;
        seqIf.wr_data = '0;
        seqIf.seq_len = 5'd2;
        seqIf.loop = 1'b0;
        seqIf.start = 1'b0;
        seqIf.stop = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstState", {8'd0, seqIf.busy, seqIf.play, seqIf.done, seqIf.cur_index, seqIf.note_period}, 32'd0);
        rstN = 1'b1;

        // Basic two-note melody, then a rest and a further pitch.
        writeEntry(0, {4'd10, 4'd0});
        writeEntry(1, {4'd1, 4'd1});
        playMelody(2);
        writeEntry(2, {4'd0, 4'd2});
        writeEntry(3, {4'd8, 4'd0});
        seqIf.seq_len = 5'd4;
        playMelody(4);

        // Looping melody aborted by stop mid-note.
        seqIf.seq_len = 5'd2;
        seqIf.loop = 1'b1;
        applyStimulus(1'b1, 1'b0);
        pushEntry(0, -1); pushEntry(1, -1); pushEntry(0, -1); pushEntry(1, -1); pushEntry(0, 5);
        endPulse();
        waitDrain();
        applyStimulus(1'b0, 1'b1);
        pushIdle(2);
        endPulse();
        waitDrain();
        seqIf.loop = 1'b0;

        // Start and stop together in IDLE: start must lose.
        applyStimulus(1'b1, 1'b1);
        pushIdle(3);
        endPulse();
        waitDrain();

        // Dropping mode mid-note behaves as stop.
        seqIf.seq_len = 5'd4;
        applyStimulus(1'b1, 1'b0);
        pushEntry(0, -1); pushEntry(1, 7);
        endPulse();
        waitDrain();
        @(negedge clk);
        seqIf.mode = 1'b0;
        pushIdle(2);
        endPulse();
        waitDrain();

        // Asynchronous reset mid-note clears outputs without a clock edge; memory survives.
        seqIf.seq_len = 5'd2;
        applyStimulus(1'b1, 1'b0);
        pushEntry(0, 4);
        endPulse();
        waitDrain();
        @(negedge clk);
        #2 rstN = 1'b0;
        #1 checkOutput("rstAsync", {8'd0, seqIf.busy, seqIf.play, seqIf.done, seqIf.cur_index, seqIf.note_period}, 32'd0);
        modelPeriod = 0;
        @(negedge clk);
        rstN = 1'b1;
        playMelody(2);

        // Ignored starts: listen mode, and zero length.
        @(negedge clk);
        seqIf.mode = 1'b0;
        seqIf.start = 1'b1;
        pushIdle(2);
        endPulse();
        waitDrain();
        seqIf.seq_len = 5'd0;
        applyStimulus(1'b1, 1'b0);
        pushIdle(2);
        endPulse();
        waitDrain();

        // Writes while busy are dropped; replay shows the original entry 0.
        seqIf.seq_len = 5'd1;
        applyStimulus(1'b1, 1'b0);
        pushEntry(0, -1);
        pushDone(0);
        endPulse();
        repeat (3) @(negedge clk);
        seqIf.wr_en = 1'b1;
        seqIf.wr_addr = 4'd0;
        seqIf.wr_data = {4'd1, 4'd3};
        @(negedge clk);
        seqIf.wr_en = 1'b0;
        waitDrain();
        playMelody(1);

        // Write and start in the same cycle: LOAD sees the new data.
        @(negedge clk);
        seqIf.wr_en = 1'b1;
        seqIf.wr_addr = 4'd0;
        seqIf.wr_data = {4'd8, 4'd1};
        memModel[0] = {4'd8, 4'd1};
        seqIf.start = 1'b1;
        pushEntry(0, -1);
        pushDone(0);
        endPulse();
        waitDrain();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
